// File: rtl/nic_rx_vc_buffer.sv
// Per-VC receive FIFOs for the router-to-node link. Whole packets are granted round-robin
// to the depacketiser. A credit pulse is returned per consumed flit and a free pulse per tail.
module nic_rx_vc_buffer #(
    parameter int unsigned FLIT_WIDTH  = 16,
    parameter int unsigned N_OF_VC     = 2,
    parameter int unsigned N_OF_VN     = 2,
    parameter int unsigned N_TOT_OF_VC = N_OF_VC * N_OF_VN,
    parameter int unsigned VC_IDX_W    = $clog2(N_TOT_OF_VC),
    parameter int unsigned DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_WIDTH-1:0]  in_link_i,
    input  logic                   is_valid_i,
    output logic [N_TOT_OF_VC-1:0] credit_signal_o,
    output logic [N_TOT_OF_VC-1:0] free_signal_o,
    output logic [FLIT_WIDTH-1:0]  out_flit_o,
    output logic [VC_IDX_W-1:0]    out_vc_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   overflow_o,
    output logic                   proto_err_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e state_q, state_d;

    logic [FLIT_WIDTH-1:0] mem_q  [N_TOT_OF_VC][DEPTH];
    logic [PtrW-1:0]       rptr_q [N_TOT_OF_VC];
    logic [PtrW-1:0]       wptr_q [N_TOT_OF_VC];
    logic [CntW-1:0]       cnt_q  [N_TOT_OF_VC];

    logic [FLIT_WIDTH-1:0]  front_flit [N_TOT_OF_VC];
    logic [N_TOT_OF_VC-1:0] is_head, eligible, stray, full;

    logic [VC_IDX_W-1:0]    last_grant_q, out_vc_q;
    logic [N_TOT_OF_VC-1:0] credit_q, free_q;
    logic                   overflow_q, proto_err_q;

    logic                   grant_found;
    logic [VC_IDX_W-1:0]    grant_vc;
    logic [VC_IDX_W:0]      rr_idx;
    logic                   discard_en;
    logic [VC_IDX_W-1:0]    discard_vc;
    logic                   pop_en;
    logic [VC_IDX_W-1:0]    pop_vc;
    logic [FLIT_WIDTH-1:0]  pop_flit;
    logic [N_TOT_OF_VC-1:0] push_vec, pop_vec;
    logic [VC_IDX_W-1:0]    wr_vc;
    logic                   wr_accept;

    always_comb begin
        for (int unsigned v = 0; v < N_TOT_OF_VC; v++) begin
            front_flit[v] = mem_q[v][rptr_q[v]];
            full[v]       = (cnt_q[v] == CntW'(DEPTH));
            is_head[v]    = (front_flit[v][1:0] == 2'b00) || (front_flit[v][1:0] == 2'b11);
            eligible[v]   = (cnt_q[v] != '0) && is_head[v];
            stray[v]      = (cnt_q[v] != '0) && !is_head[v];
        end
    end

    // Round-robin search starting just after the last granted VC.
    always_comb begin
        grant_found = 1'b0;
        grant_vc    = '0;
        rr_idx      = '0;
        for (int unsigned i = 1; i <= N_TOT_OF_VC; i++) begin
            rr_idx = {1'b0, last_grant_q} + (VC_IDX_W + 1)'(i);
            if (rr_idx >= (VC_IDX_W + 1)'(N_TOT_OF_VC)) begin
                rr_idx = rr_idx - (VC_IDX_W + 1)'(N_TOT_OF_VC);
            end
            if (!grant_found && eligible[rr_idx[VC_IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_vc    = rr_idx[VC_IDX_W-1:0];
            end
        end
        discard_en = 1'b0;
        discard_vc = '0;
        for (int i = int'(N_TOT_OF_VC) - 1; i >= 0; i--) begin
            if (stray[i]) begin
                discard_en = 1'b1;
                discard_vc = VC_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant_found) state_d = StLocked;
            StLocked: if (pop_en && pop_flit[1]) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // In IDLE a stray body/tail flit is dropped only when nothing can be granted.
    always_comb begin
        out_valid_o = 1'b0;
        pop_en      = 1'b0;
        pop_vc      = '0;
        unique case (state_q)
            StIdle: begin
                pop_en = !grant_found && discard_en;
                pop_vc = discard_vc;
            end
            StLocked: begin
                out_valid_o = (cnt_q[out_vc_q] != '0);
                pop_en      = out_valid_o && out_ready_i;
                pop_vc      = out_vc_q;
            end
            default: ;
        endcase
        pop_flit   = front_flit[pop_vc];
        out_flit_o = out_valid_o ? front_flit[out_vc_q] : '0;
    end

    // A full VC still accepts a write when it is popped in the same cycle.
    always_comb begin
        wr_vc   = in_link_i[2 +: VC_IDX_W];
        pop_vec = '0;
        if (pop_en) pop_vec[pop_vc] = 1'b1;
        wr_accept = is_valid_i && (!full[wr_vc] || pop_vec[wr_vc]);
        push_vec  = '0;
        if (wr_accept) push_vec[wr_vc] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < N_TOT_OF_VC; v++) begin
            if (push_vec[v]) mem_q[v][wptr_q[v]] <= in_link_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < N_TOT_OF_VC; v++) begin
                rptr_q[v] <= '0;
                wptr_q[v] <= '0;
                cnt_q[v]  <= '0;
            end
        end else begin
            for (int unsigned v = 0; v < N_TOT_OF_VC; v++) begin
                if (push_vec[v]) wptr_q[v] <= wptr_q[v] + PtrW'(1);
                if (pop_vec[v])  rptr_q[v] <= rptr_q[v] + PtrW'(1);
                if (push_vec[v] && !pop_vec[v]) begin
                    cnt_q[v] <= cnt_q[v] + CntW'(1);
                end else if (!push_vec[v] && pop_vec[v]) begin
                    cnt_q[v] <= cnt_q[v] - CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= VC_IDX_W'(N_TOT_OF_VC - 1);
            out_vc_q     <= '0;
            credit_q     <= '0;
            free_q       <= '0;
            overflow_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            if (state_q == StIdle && grant_found) begin
                last_grant_q <= grant_vc;
                out_vc_q     <= grant_vc;
            end
            credit_q <= pop_vec;
            free_q   <= pop_flit[1] ? pop_vec : '0;
            if (is_valid_i && !wr_accept)   overflow_q  <= 1'b1;
            if (state_q == StIdle && pop_en) proto_err_q <= 1'b1;
        end
    end

    assign credit_signal_o = credit_q;
    assign free_signal_o   = free_q;
    assign out_vc_o        = out_vc_q;
    assign overflow_o      = overflow_q;
    assign proto_err_o     = proto_err_q;

endmodule

// File: tb/tb_nic_rx_vc_buffer.sv
// Scoreboard bench for nic_rx_vc_buffer: expected flits are queued as they are driven
// and checked as they leave; credit and free pulses are tallied per VC.
module tb_nic_rx_vc_buffer;
    localparam int unsigned NV = 4;

    localparam logic [15:0] T2_FLIT [7] = '{16'hA004, 16'hB005, 16'h0000, 16'hC005,
                                            16'hD006, 16'h0000, 16'h0000};
    localparam logic        T2_VLD  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic        T2_RDY  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   in_link_i;
    logic          is_valid_i;
    logic [NV-1:0] credit_signal_o;
    logic [NV-1:0] free_signal_o;
    logic [15:0]   out_flit_o;
    logic [1:0]    out_vc_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          overflow_o;
    logic          proto_err_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int credit_cnt [NV];
    int free_cnt   [NV];
    int free_at    [NV];
    int hs_cyc [$];
    logic [17:0] sb_q [$];
    logic [17:0] sb_exp;
    int c0, f0, tot_c, tot_f;

    nic_rx_vc_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .in_link_i       (in_link_i),
        .is_valid_i      (is_valid_i),
        .credit_signal_o (credit_signal_o),
        .free_signal_o   (free_signal_o),
        .out_flit_o      (out_flit_o),
        .out_vc_o        (out_vc_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .overflow_o      (overflow_o),
        .proto_err_o     (proto_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] f, input bit exp_out);
        in_link_i  = f;
        is_valid_i = 1'b1;
        if (exp_out) sb_q.push_back({f[3:2], f});
        tick();
        is_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check_eq({tag, "_drain"}, sb_q.size(), 0);
    endtask

    task automatic sum_pulses(output int c, output int f);
        c = 0;
        f = 0;
        for (int v = 0; v < int'(NV); v++) begin
            c += credit_cnt[v];
            f += free_cnt[v];
        end
    endtask

    // Output monitor: pulse tallies and scoreboard comparison away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int v = 0; v < int'(NV); v++) begin
                if (credit_signal_o[v]) credit_cnt[v]++;
                if (free_signal_o[v]) begin
                    free_cnt[v]++;
                    free_at[v] = credit_cnt[v];
                end
            end
            if (out_valid_o) begin
                sb_exp = (sb_q.size() > 0) ? sb_q[0] : ~{out_vc_o, out_flit_o};
                if (out_ready_i) begin
                    check_eq("sb_pop", {out_vc_o, out_flit_o}, sb_exp);
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                    hs_cyc.push_back(cyc);
                end else begin
                    check_eq("sb_hold", {out_vc_o, out_flit_o}, sb_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int v = 0; v < int'(NV); v++) begin
            credit_cnt[v] = 0;
            free_cnt[v]   = 0;
            free_at[v]    = 0;
        end
        rst         = 1'b1;
        in_link_i   = '0;
        is_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_valid",   out_valid_o,     0);
        check_eq("rst_flit",    out_flit_o,      0);
        check_eq("rst_vc",      out_vc_o,        0);
        check_eq("rst_credit",  credit_signal_o, 0);
        check_eq("rst_free",    free_signal_o,   0);
        check_eq("rst_ovf",     overflow_o,      0);
        check_eq("rst_proto",   proto_err_o,     0);

        // Single head-tail flit on VC0
        out_ready_i = 1'b1;
        send(16'h6F03, 1'b1);
        check_eq("t1_valid_early", out_valid_o, 0);
        tick();
        check_eq("t1_valid",  out_valid_o, 1);
        check_eq("t1_flit",   out_flit_o,  16'h6F03);
        check_eq("t1_vc",     out_vc_o,    0);
        tick();
        check_eq("t1_credit", credit_signal_o, 4'b0001);
        check_eq("t1_free",   free_signal_o,   4'b0001);
        check_eq("t1_idle",   out_valid_o,     0);
        tick();
        check_eq("t1_credit_off", credit_signal_o, 0);
        check_eq("t1_free_off",   free_signal_o,   0);

        // Four-flit packet on VC1 with an input gap and backpressure
        c0 = credit_cnt[1];
        f0 = free_cnt[1];
        for (int i = 0; i < 7; i++) begin
            in_link_i   = T2_FLIT[i];
            is_valid_i  = T2_VLD[i];
            out_ready_i = T2_RDY[i];
            if (T2_VLD[i]) sb_q.push_back({2'd1, T2_FLIT[i]});
            tick();
        end
        is_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        wait_drain("t2");
        check_eq("t2_credits",   credit_cnt[1] - c0, 4);
        check_eq("t2_frees",     free_cnt[1] - f0,   1);
        check_eq("t2_free_last", free_at[1] - c0,    4);

        // Interleaved head-tail arrivals on VC0 / VC2, then a second VC0 packet
        hs_cyc.delete();
        send(16'h1113, 1'b1);
        send(16'h222B, 1'b1);
        send(16'h3333, 1'b1);
        wait_drain("t3");
        check_eq("t3_handshakes", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            check_eq("t3_gap_a", hs_cyc[1] - hs_cyc[0], 2);
            check_eq("t3_gap_b", hs_cyc[2] - hs_cyc[1], 2);
        end

        // Overflow on VC3
        out_ready_i = 1'b0;
        c0 = credit_cnt[3];
        f0 = free_cnt[3];
        send(16'h010C, 1'b1);
        send(16'h020D, 1'b1);
        send(16'h030D, 1'b1);
        send(16'h040E, 1'b1);
        send(16'h050D, 1'b0);
        check_eq("t4_ovf",       overflow_o,  1);
        check_eq("t4_valid",     out_valid_o, 1);
        check_eq("t4_vc",        out_vc_o,    3);
        repeat (3) tick();
        check_eq("t4_ovf_hold",  overflow_o,  1);
        out_ready_i = 1'b1;
        wait_drain("t4");
        check_eq("t4_credits",   credit_cnt[3] - c0, 4);
        check_eq("t4_frees",     free_cnt[3] - f0,   1);
        check_eq("t4_ovf_stick", overflow_o,  1);

        // Lone body flit on VC0 while idle
        c0 = credit_cnt[0];
        f0 = free_cnt[0];
        check_eq("t5_proto_pre", proto_err_o, 0);
        send(16'h1231, 1'b0);
        tick();
        check_eq("t5_credit",    credit_signal_o, 4'b0001);
        check_eq("t5_free",      free_signal_o,   0);
        check_eq("t5_proto",     proto_err_o,     1);
        check_eq("t5_no_out",    out_valid_o,     0);
        tick();
        check_eq("t5_credit_off", credit_signal_o, 0);
        send(16'h4003, 1'b1);
        wait_drain("t5");
        check_eq("t5_credits",   credit_cnt[0] - c0, 2);
        check_eq("t5_frees",     free_cnt[0] - f0,   1);
        check_eq("t5_proto_stick", proto_err_o,      1);

        // Reset while a three-flit VC1 packet is locked
        out_ready_i = 1'b0;
        send(16'h1104, 1'b1);
        send(16'h2205, 1'b1);
        send(16'h3306, 1'b1);
        tick();
        check_eq("t6_locked", out_valid_o, 1);
        rst = 1'b1;
        sb_q.delete();
        sum_pulses(tot_c, tot_f);
        tick();
        rst = 1'b0;
        check_eq("t6_valid",  out_valid_o,     0);
        check_eq("t6_flit",   out_flit_o,      0);
        check_eq("t6_vc",     out_vc_o,        0);
        check_eq("t6_credit", credit_signal_o, 0);
        check_eq("t6_free",   free_signal_o,   0);
        check_eq("t6_ovf",    overflow_o,      0);
        check_eq("t6_proto",  proto_err_o,     0);
        out_ready_i = 1'b1;
        repeat (4) tick();
        sum_pulses(c0, f0);
        check_eq("t6_no_credit", c0 - tot_c, 0);
        check_eq("t6_no_free",   f0 - tot_f, 0);
        c0 = credit_cnt[1];
        send(16'h5507, 1'b1);
        wait_drain("t6");
        check_eq("t6_credits", credit_cnt[1] - c0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
